sequential_divider: RTL and testbench
=====================================

// Module: sequential_divider
// PURPOSE
// - Multi-cycle unsigned restoring divider (shift-subtract): the inverse of the team's shift-add multiplier.
// - Computes quotient = dividend / divisor and remainder = dividend % divisor.
// - Retires one quotient bit per clock and shares the start/handshake style of the multiplier path.
// - Sits beside the multiplier in the arithmetic datapath, driven by the same controller.
// PARAMETERS
// - D_SIZE  default 8  operand/result width in bits; must be >= 2.
// PORTS
// - clk_in         in   1       single clock; all state changes on posedge.
// - rst_in         in   1       synchronous, active-low reset.
// - strt_in        in   1       start request; sampled on posedge, accepted only in IDLE.
// - dividend_in    in   D_SIZE  unsigned dividend; latched on the accepting edge.
// - divisor_in     in   D_SIZE  unsigned divisor; latched on the accepting edge.
// - busy_out       out  1       high in RUN and DONE.
// - done_out       out  1       one-cycle pulse; results valid.
// - div_zero_out   out  1       divisor was 0 for the last operation; held until the next accept.
// - quotient_out   out  D_SIZE  quotient, registered.
// - remainder_out  out  D_SIZE  remainder, registered.
// BEHAVIOUR
// - Reset (rst_in==0 at posedge): state=IDLE, count=0; all outputs and internal registers are 0.
//   - Reset has priority over every other event, including mid-operation; a partial result is discarded.
// - FSM states: IDLE -> RUN -> DONE -> IDLE.
// - IDLE: on strt_in=1, latch operands, clear div_zero_out and go to RUN.
//   - If divisor_in==0, go to DONE instead.
// - RUN: one iteration per edge; count increments 0..D_SIZE-1.
//   - On the edge with count==D_SIZE-1, go to DONE.
// - DONE: done_out=1 for exactly this one cycle; the next edge always returns to IDLE.
//   - strt_in in DONE is ignored, so back-to-back operations have one IDLE cycle between them.
// - strt_in while in RUN or DONE is ignored; the latched operands are unaffected by input changes.
// - Iteration, with working R (D_SIZE+1 bits) and Q (D_SIZE bits), initialised R=0 and Q=dividend:
//   - sh = {R[D_SIZE-1:0], Q[D_SIZE-1]};
//   - t  = sh - {1'b0, divisor}   (D_SIZE+1 bits);
//   - if t[D_SIZE]==0: R=t,  Q={Q[D_SIZE-2:0],1'b1};
//   - else:            R=sh, Q={Q[D_SIZE-2:0],1'b0}.
// - Latency, accepting edge = edge 0:
//   - normal: D_SIZE iteration edges (1..D_SIZE); done_out is high in the cycle after edge D_SIZE.
//   - divide-by-zero: done_out is high in the cycle after edge 0.
// - Results: quotient_out=Q and remainder_out=R[D_SIZE-1:0], loaded on the edge entering DONE.
//   - Held stable until the next accept or reset.
// - Divide-by-zero: quotient_out = all ones, remainder_out = dividend, div_zero_out = 1.
// - Boundaries:
//   - dividend < divisor gives q=0, r=dividend.
//   - divisor=1 gives q=dividend, r=0.
//   - dividend == divisor gives q=1, r=0.
//   - No overflow is possible for unsigned operands.
// - Counter width is $clog2(D_SIZE+1); the count never wraps and is cleared on the accept.
// STRUCTURE
// - Package div_pkg:
//   - typedef enum logic [1:0] {DIV_IDLE, DIV_RUN, DIV_DONE} div_state_t;
//   - function cnt_w(int d) returning $clog2(d+1).
// - Sub-module div_step #(D_SIZE): combinational single iteration.
//   - Inputs: R, Q, divisor.  Outputs: next R, next Q.
//   - Instantiated once; the top level holds the FSM, counter, operand and result registers.
// TESTING (D_SIZE=8 unless noted)
// - 100/7 -> q=14, r=2, div_zero_out=0; done_out is a single-cycle pulse 8 edges after accept.
// - 5/9 -> q=0, r=5.   255/1 -> q=255, r=0.   200/200 -> q=1, r=0.
// - 42/0 -> q=255, r=42, div_zero_out=1; done_out 1 edge after accept; the next accept (6/3) clears the flag and gives q=2, r=0.
// - Start 100/7, hold strt_in=1 with new operands (9/2) through RUN and DONE -> only 14 r2 is reported.
//   - The next accept then requires IDLE.
// - Start 255/16, assert rst_in=0 at iteration 4 -> next cycle: IDLE, all outputs 0, no done_out.
//   - A new start 255/16 then completes with q=15, r=15.
// - Random sweep at D_SIZE=4 and D_SIZE=16 against a reference model, including divisor=0 and divisor=max.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and sizing helpers for the sequential restoring divider.
package div_pkg;

    typedef enum logic [1:0] {DIV_IDLE, DIV_RUN, DIV_DONE} div_state_t;

    function automatic int cnt_w(input int d);
        return $clog2(d + 1);
    endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift in the next dividend bit,
// trial-subtract the divisor, keep the difference only if it did not go negative.
module div_step
    import div_pkg::*;
#(
    parameter int D_SIZE = 8
) (
    input  logic [D_SIZE-1:0] r_in,
    input  logic [D_SIZE-1:0] q_in,
    input  logic [D_SIZE-1:0] divisor_in,
    output logic [D_SIZE-1:0] r_out,
    output logic [D_SIZE-1:0] q_out
);

    logic [D_SIZE:0] sh;
    logic [D_SIZE:0] t;

    // The partial remainder is always below the divisor, so its top bit is implicitly 0.
    always_comb begin
        sh    = {r_in, q_in[D_SIZE-1]};
        t     = sh - {1'b0, divisor_in};
        q_out = {q_in[D_SIZE-2:0], ~t[D_SIZE]};
        if (!t[D_SIZE]) begin
            r_out = t[D_SIZE-1:0];
        end else begin
            r_out = sh[D_SIZE-1:0];
        end
    end

endmodule

// File: rtl/sequential_divider.sv
// Multi-cycle unsigned restoring divider retiring one quotient bit per clock,
// with the same start/busy/done handshake as the shift-add multiplier.
module sequential_divider
    import div_pkg::*;
#(
    parameter int D_SIZE = 8
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              strt_in,
    input  logic [D_SIZE-1:0] dividend_in,
    input  logic [D_SIZE-1:0] divisor_in,
    output logic              busy_out,
    output logic              done_out,
    output logic              div_zero_out,
    output logic [D_SIZE-1:0] quotient_out,
    output logic [D_SIZE-1:0] remainder_out
);

    localparam int CNT_W = cnt_w(D_SIZE);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(D_SIZE - 1);

    div_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [D_SIZE-1:0] r_q, r_d;
    logic [D_SIZE-1:0] q_q, q_d;
    logic [D_SIZE-1:0] dvsr_q, dvsr_d;
    logic [D_SIZE-1:0] quot_q, quot_d;
    logic [D_SIZE-1:0] rem_q, rem_d;
    logic              dz_q, dz_d;

    logic [D_SIZE-1:0] step_r;
    logic [D_SIZE-1:0] step_q;

    div_step #(.D_SIZE(D_SIZE)) u_step (
        .r_in       (r_q),
        .q_in       (q_q),
        .divisor_in (dvsr_q),
        .r_out      (step_r),
        .q_out      (step_q)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        q_d     = q_q;
        dvsr_d  = dvsr_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dz_d    = dz_q;

        case (state_q)
            DIV_IDLE: begin
                if (strt_in) begin
                    cnt_d  = '0;
                    r_d    = '0;
                    q_d    = dividend_in;
                    dvsr_d = divisor_in;
                    dz_d   = 1'b0;
                    // A zero divisor skips the iterations and reports immediately.
                    if (divisor_in == '0) begin
                        state_d = DIV_DONE;
                        dz_d    = 1'b1;
                        quot_d  = '1;
                        rem_d   = dividend_in;
                    end else begin
                        state_d = DIV_RUN;
                    end
                end
            end
            DIV_RUN: begin
                r_d = step_r;
                q_d = step_q;
                if (cnt_q == CNT_LAST) begin
                    state_d = DIV_DONE;
                    quot_d  = step_q;
                    rem_d   = step_r;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DIV_DONE: begin
                state_d = DIV_IDLE;
            end
            default: begin
                state_d = DIV_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q <= DIV_IDLE;
            cnt_q   <= '0;
            r_q     <= '0;
            q_q     <= '0;
            dvsr_q  <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            q_q     <= q_d;
            dvsr_q  <= dvsr_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dz_q    <= dz_d;
        end
    end

    assign busy_out      = (state_q != DIV_IDLE);
    assign done_out      = (state_q == DIV_DONE);
    assign div_zero_out  = dz_q;
    assign quotient_out  = quot_q;
    assign remainder_out = rem_q;

endmodule

// File: tb/tb_sequential_divider.sv
// Self-checking bench for sequential_divider at widths 4, 8 and 16 against a plain-arithmetic model.
module tb_sequential_divider;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic        s4 = 0, s8 = 0, s16 = 0;
    logic [3:0]  a4 = 0, b4 = 0;
    logic [7:0]  a8 = 0, b8 = 0;
    logic [15:0] a16 = 0, b16 = 0;
    logic        busy4, done4, dz4, busy8, done8, dz8, busy16, done16, dz16;
    logic [3:0]  q4, r4;
    logic [7:0]  q8, r8;
    logic [15:0] q16, r16;

    sequential_divider #(.D_SIZE(4)) dut4 (
        .clk_in(clk), .rst_in(rst_n), .strt_in(s4), .dividend_in(a4), .divisor_in(b4),
        .busy_out(busy4), .done_out(done4), .div_zero_out(dz4),
        .quotient_out(q4), .remainder_out(r4));

    sequential_divider #(.D_SIZE(8)) dut8 (
        .clk_in(clk), .rst_in(rst_n), .strt_in(s8), .dividend_in(a8), .divisor_in(b8),
        .busy_out(busy8), .done_out(done8), .div_zero_out(dz8),
        .quotient_out(q8), .remainder_out(r8));

    sequential_divider #(.D_SIZE(16)) dut16 (
        .clk_in(clk), .rst_in(rst_n), .strt_in(s16), .dividend_in(a16), .divisor_in(b16),
        .busy_out(busy16), .done_out(done16), .div_zero_out(dz16),
        .quotient_out(q16), .remainder_out(r16));

    function automatic logic get_done(input int w);
        case (w)
            4:       return done4;
            8:       return done8;
            default: return done16;
        endcase
    endfunction

    function automatic logic get_dz(input int w);
        case (w)
            4:       return dz4;
            8:       return dz8;
            default: return dz16;
        endcase
    endfunction

    function automatic logic [31:0] get_q(input int w);
        case (w)
            4:       return 32'(q4);
            8:       return 32'(q8);
            default: return 32'(q16);
        endcase
    endfunction

    function automatic logic [31:0] get_r(input int w);
        case (w)
            4:       return 32'(r4);
            8:       return 32'(r8);
            default: return 32'(r16);
        endcase
    endfunction

    task automatic drive(input int w, input logic s, input logic [31:0] a, input logic [31:0] b);
        case (w)
            4:       begin s4 = s;  a4 = a[3:0];   b4 = b[3:0];   end
            8:       begin s8 = s;  a8 = a[7:0];   b8 = b[7:0];   end
            default: begin s16 = s; a16 = a[15:0]; b16 = b[15:0]; end
        endcase
    endtask

    // One full operation; lat counts posedges after the accepting edge until done is seen.
    task automatic op(input int w, input logic [31:0] a, input logic [31:0] b,
                      output logic [31:0] q, output logic [31:0] r, output logic z,
                      output int lat, output bit timeout, output bit pulse_ok);
        @(negedge clk);
        drive(w, 1'b1, a, b);
        @(negedge clk);
        drive(w, 1'b0, a, b);
        lat = 0;
        while (!get_done(w) && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        timeout = !get_done(w);
        q = get_q(w);
        r = get_r(w);
        z = get_dz(w);
        @(negedge clk);
        pulse_ok = !get_done(w);
    endtask

    task automatic test_reset;
        logic [31:0] outs;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        outs = {busy8, done8, dz8, q8, r8};
        checks++;
        if (outs !== 32'd0) begin
            errors++;
            $display("FAIL reset8: outputs=%h required 0", outs);
        end
        outs = {busy16, done16, dz16, q16[4:0], r4, q4, busy4, done4, dz4};
        checks++;
        if (outs !== 32'd0) begin
            errors++;
            $display("FAIL reset_others: outputs=%h required 0", outs);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic;
        logic [7:0] ta [4] = '{8'd100, 8'd5, 8'd255, 8'd200};
        logic [7:0] tb [4] = '{8'd7,   8'd9, 8'd1,   8'd200};
        logic [31:0] q, r, eq, er;
        logic z;
        int lat;
        bit to, pulse_ok;
        for (int i = 0; i < 4; i++) begin
            op(8, 32'(ta[i]), 32'(tb[i]), q, r, z, lat, to, pulse_ok);
            eq = 32'(ta[i]) / 32'(tb[i]);
            er = 32'(ta[i]) % 32'(tb[i]);
            checks++;
            if (to || q !== eq || r !== er || z !== 1'b0) begin
                errors++;
                $display("FAIL basic %0d/%0d: q=%0d r=%0d z=%0b to=%0b required q=%0d r=%0d z=0",
                         ta[i], tb[i], q, r, z, to, eq, er);
            end
            checks++;
            if (lat != 8 || !pulse_ok) begin
                errors++;
                $display("FAIL basic_latency %0d/%0d: lat=%0d single=%0b required lat=8 single=1",
                         ta[i], tb[i], lat, pulse_ok);
            end
        end
    endtask

    task automatic test_div_zero;
        logic [31:0] q, r;
        logic z;
        int lat;
        bit to, pulse_ok;
        op(8, 32'd42, 32'd0, q, r, z, lat, to, pulse_ok);
        checks++;
        if (to || q !== 32'd255 || r !== 32'd42 || z !== 1'b1) begin
            errors++;
            $display("FAIL div_zero: q=%0d r=%0d z=%0b required q=255 r=42 z=1", q, r, z);
        end
        checks++;
        if (lat != 0 || !pulse_ok) begin
            errors++;
            $display("FAIL div_zero_latency: lat=%0d single=%0b required lat=0 single=1", lat, pulse_ok);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (dz8 !== 1'b1 || q8 !== 8'd255 || r8 !== 8'd42) begin
            errors++;
            $display("FAIL div_zero_hold: z=%0b q=%0d r=%0d required z=1 q=255 r=42", dz8, q8, r8);
        end
        s8 = 1'b1; a8 = 8'd6; b8 = 8'd3;
        @(negedge clk);
        s8 = 1'b0;
        checks++;
        if (dz8 !== 1'b0 || busy8 !== 1'b1) begin
            errors++;
            $display("FAIL div_zero_clear: z=%0b busy=%0b required z=0 busy=1", dz8, busy8);
        end
        lat = 0;
        while (!done8 && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat != 8 || q8 !== 8'd2 || r8 !== 8'd0 || dz8 !== 1'b0) begin
            errors++;
            $display("FAIL after_zero 6/3: lat=%0d q=%0d r=%0d z=%0b required lat=8 q=2 r=0 z=0",
                     lat, q8, r8, dz8);
        end
        @(negedge clk);
    endtask

    task automatic test_ignore_start;
        int lat;
        @(negedge clk);
        s8 = 1'b1; a8 = 8'd100; b8 = 8'd7;
        @(negedge clk);
        a8 = 8'd9; b8 = 8'd2;
        lat = 0;
        while (!done8 && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat != 8 || q8 !== 8'd14 || r8 !== 8'd2) begin
            errors++;
            $display("FAIL ignore_start: lat=%0d q=%0d r=%0d required lat=8 q=14 r=2", lat, q8, r8);
        end
        @(negedge clk);
        checks++;
        if (busy8 !== 1'b0 || done8 !== 1'b0) begin
            errors++;
            $display("FAIL start_in_done: busy=%0b done=%0b required busy=0 done=0", busy8, done8);
        end
        @(negedge clk);
        s8 = 1'b0;
        checks++;
        if (busy8 !== 1'b1 || q8 !== 8'd14) begin
            errors++;
            $display("FAIL accept_from_idle: busy=%0b q=%0d required busy=1 q=14", busy8, q8);
        end
        lat = 0;
        while (!done8 && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat != 8 || q8 !== 8'd4 || r8 !== 8'd1) begin
            errors++;
            $display("FAIL back_to_back 9/2: lat=%0d q=%0d r=%0d required lat=8 q=4 r=1", lat, q8, r8);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        logic [31:0] q, r;
        logic z;
        int lat;
        int seen_done;
        bit to, pulse_ok;
        @(negedge clk);
        s8 = 1'b1; a8 = 8'd255; b8 = 8'd16;
        @(negedge clk);
        s8 = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if ({busy8, done8, dz8, q8, r8} !== 19'd0) begin
            errors++;
            $display("FAIL reset_mid: busy=%0b done=%0b z=%0b q=%0d r=%0d required all 0",
                     busy8, done8, dz8, q8, r8);
        end
        seen_done = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done8 || busy8) seen_done++;
        end
        checks++;
        if (seen_done != 0) begin
            errors++;
            $display("FAIL reset_mid_quiet: active cycles=%0d required 0", seen_done);
        end
        op(8, 32'd255, 32'd16, q, r, z, lat, to, pulse_ok);
        checks++;
        if (to || lat != 8 || q !== 32'd15 || r !== 32'd15 || z !== 1'b0) begin
            errors++;
            $display("FAIL restart 255/16: lat=%0d q=%0d r=%0d z=%0b required lat=8 q=15 r=15 z=0",
                     lat, q, r, z);
        end
    endtask

    task automatic test_random_sweep(input int w);
        logic [31:0] mask, a, b, q, r, eq, er;
        logic z, ez;
        int lat, elat;
        bit to, pulse_ok;
        mask = (32'd1 << w) - 32'd1;
        for (int i = 0; i < 40; i++) begin
            a = $urandom() & mask;
            if (i % 10 == 3) a = mask;
            case (i % 8)
                0:       b = 32'd0;
                1:       b = mask;
                2:       b = 32'd1;
                default: b = $urandom() & mask;
            endcase
            if (b == 32'd0) begin
                eq = mask; er = a; ez = 1'b1; elat = 0;
            end else begin
                eq = a / b; er = a % b; ez = 1'b0; elat = w;
            end
            op(w, a, b, q, r, z, lat, to, pulse_ok);
            checks++;
            if (to || q !== eq || r !== er || z !== ez || lat != elat || !pulse_ok) begin
                errors++;
                $display("FAIL sweep_w%0d %0d/%0d: q=%0d r=%0d z=%0b lat=%0d single=%0b required q=%0d r=%0d z=%0b lat=%0d single=1",
                         w, a, b, q, r, z, lat, pulse_ok, eq, er, ez, elat);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_div_zero();
        test_ignore_start();
        test_reset_mid();
        test_random_sweep(4);
        test_random_sweep(16);
        test_random_sweep(8);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
